mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single-port unified memory between instruction fetch (IF) and load/store (D) in the RV32 core. It serialises the two requesters onto one req/ack memory port and asserts a stall toward PC while either requester is waiting. Data requests win by default, and a starvation guard guarantees forward progress for fetch. A timeout abandons memory accesses that are never acknowledged.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive D grants tolerated while IF waits (≥1)
- TIMEOUT, 64, BUSY cycles before a transaction is abandoned (≥2)

- clk_i  in  1  clock; everything on rising edge
- rst_i  in  1  reset, synchronous, active-low
- start_i  in  1  IF requests are considered only while high; D is unaffected
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_done_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word, valid with if_done_o, held until next IF completion
- if_done_o  out  1  one-cycle completion pulse
- d_req_i  in  1  data request; held stable with d_we_i/d_addr_i/d_wdata_i until d_done_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data, valid with d_done_o, held until next D completion
- d_done_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  memory request, held until ack or timeout
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  write data
- mem_rdata_i  in  DATA_W  read data, valid in the ack cycle
- mem_ack_i  in  1  completion; ignored while mem_req_o=0
- stall_o  out  1  combinational: (if_req_i&start_i&~if_done_o) | (d_req_i&~d_done_o)
- timeout_o  out  1  sticky: a transaction timed out

## Operation
- States: IDLE, BUSY, RESP. A register `owner` records IF or D.
- IDLE: if no eligible request, stay. Otherwise choose an owner:
  - D wins if d_req_i, unless starve_cnt==STARVE_LIMIT and IF is eligible (if_req_i&start_i). In that case IF wins.
  - Otherwise IF wins if eligible.
- Granting loads mem_addr_o/mem_we_o/mem_wdata_o from the winner, sets mem_req_o=1, and moves to BUSY. An IF grant always has mem_we_o=0 and mem_wdata_o=0.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - +1 on a D grant while IF is eligible.
  - Cleared on any IF grant.
  - Unchanged otherwise; saturates at STARVE_LIMIT.
- BUSY: wait_cnt increments each cycle, starting from 0 on entry.
  - mem_ack_i=1: latch mem_rdata_i into the owner's rdata (loads and fetches only; a store leaves d_rdata_o unchanged). Drop mem_req_o and go to RESP.
  - Else if wait_cnt==TIMEOUT-1: drop mem_req_o, set timeout_o, load 0 into the owner's rdata (if it is a read), and go to RESP.
  - An ack in the same cycle as the timeout limit counts as a normal ack, and timeout_o is not set.
- RESP: owner's done pulses high for exactly this cycle. No arbitration occurs. Next state is IDLE.
- Requesters drop or renew their request in the cycle after done. A request still held during RESP is treated in IDLE as a new request.
- Reset (rst_i=0 at an edge): state IDLE, all outputs 0 (rdata, done, mem_*, timeout_o), both counters 0. An in-flight memory access is abandoned without completing.
- start_i falling during an IF transaction does not abort it.

## Timing
- Grant latency: request visible in IDLE at cycle N gives mem_req_o=1 from cycle N+1.
- Ack in cycle M gives done=1 in cycle M+1. The arbiter is back in IDLE at M+2, and the earliest next mem_req_o is at M+3.
- Zero-wait memory (ack in the first BUSY cycle): 3-cycle round trip per transaction, so peak throughput is one access per 3 cycles.
- Timeout: if mem_req_o rises at cycle N with no ack, it drops after cycle N+TIMEOUT-1 and done is at N+TIMEOUT.
- mem_* outputs are stable for the whole of BUSY.

## Test plan
- Single fetch: start_i=1, if_req_i, addr 0x10, memory acks 2 cycles after the request with 0x00A00093. Required: mem_req_o high 2 cycles, if_done_o one pulse, if_rdata_o=0x00A00093, stall_o falls with done.
- Simultaneous requests: IF 0x20 and D store 0x100/0xDEADBEEF asserted in the same cycle. Required: D granted first with mem_we_o=1, IF granted next, and d_rdata_o unchanged.
- Starvation, STARVE_LIMIT=4: IF and D held continuously. Required grant order D,D,D,D,IF,D,…, with starve_cnt clearing after the IF grant.
- Timeout, TIMEOUT=64: D load with no ack. Required: mem_req_o high exactly 64 cycles, d_done_o pulses with d_rdata_o=0, timeout_o=1 until reset.
- Ack at limit: ack arrives on BUSY cycle 63 (0-based) with TIMEOUT=64. Required: normal completion with the acked data and timeout_o=0.
- Reset mid-BUSY: rst_i=0 for one edge during an IF access. Required: all outputs 0 and IDLE next cycle, no done pulse; the next request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: serialises fetch and data requests
// onto one req/ack port, with starvation guard and access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              timeout_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d;
  logic [DATA_W-1:0] d_rd_q, d_rd_d;
  logic              to_q, to_d;

  logic if_elig;
  logic d_win;

  // owner: 1 = data port, 0 = fetch port
  assign if_elig = if_req_i & start_i;
  assign d_win   = d_req_i & ~(if_elig & (starve_q == SLIM));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if_rd_d  = if_rd_q;
    d_rd_d   = d_rd_q;
    to_d     = to_q;
    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d = BUSY;
          owner_d = 1'b1;
          req_d   = 1'b1;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          wait_d  = '0;
          // d_win with IF eligible implies starve_q < SLIM
          if (if_elig) starve_d = starve_q + 1'b1;
        end else if (if_elig) begin
          state_d  = BUSY;
          owner_d  = 1'b0;
          req_d    = 1'b1;
          we_d     = 1'b0;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          wait_d   = '0;
          starve_d = '0;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d = RESP;
          req_d   = 1'b0;
          if (!we_q) begin
            if (owner_q) d_rd_d = mem_rdata_i;
            else         if_rd_d = mem_rdata_i;
          end
        end else if (wait_q == WLIM) begin
          state_d = RESP;
          req_d   = 1'b0;
          to_d    = 1'b1;
          if (!we_q) begin
            if (owner_q) d_rd_d = '0;
            else         if_rd_d = '0;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      wait_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_rd_q  <= '0;
      d_rd_q   <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      if_rd_q  <= if_rd_d;
      d_rd_q   <= d_rd_d;
      to_q     <= to_d;
    end
  end

  assign if_done_o   = (state_q == RESP) & ~owner_q;
  assign d_done_o    = (state_q == RESP) & owner_q;
  assign if_rdata_o  = if_rd_q;
  assign d_rdata_o   = d_rd_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign timeout_o   = to_q;
  assign stall_o     = (if_req_i & start_i & ~if_done_o)
                     | (d_req_i & ~d_done_o);

endmodule
